gate_prober: RTL
================

// Module: gate_prober
// PURPOSE
//  Drive side of a combinational gate under test: generates every input pattern on
//  probe_out, waits a settle window, samples the gate output on probe_in, builds the
//  captured truth table and compares it to an expected table. Sits beside the
//  primitive gate library as the self-check engine for board and bench bring-up.
// PARAMETERS
//  N_INPUTS       2        gate input count; 1..4
//  SETTLE_CYCLES  2        cycles probe_out is held before sampling; 0..255
//  EXPECT_TT      4'b0001  expected table, width 2**N_INPUTS; bit i = output for pattern i
//                          (default = 2-input NOR)
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            synchronous, active-high reset
//  start        in   1            begin a sweep; sampled only in IDLE
//  probe_out    out  N_INPUTS     pattern driven to gate inputs (bit 0 -> first input)
//  probe_in     in   1            gate output
//  busy         out  1            high from the cycle after start through DONE
//  done         out  1            one-cycle pulse at sweep end
//  pass         out  1            captured table == EXPECT_TT; valid from done, held
//  tt_captured  out  2**N_INPUTS  captured table; held until next start
//  func_id      out  3            only with GATE_PROBER_CLASSIFY_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; probe_out=0, busy=0, done=0, pass=0, tt_captured=0, func_id=0.
//  - FSM IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//  - IDLE: start=1 -> pattern=0, probe_out=0, tt_captured=0, pass=0, settle cnt=SETTLE_CYCLES;
//    go SETTLE (SAMPLE directly if SETTLE_CYCLES==0).
//  - SETTLE: probe_out held; cnt decrements each cycle; leave to SAMPLE after exactly
//    SETTLE_CYCLES cycles.
//  - SAMPLE (1 cycle): tt_captured[pattern] <= probe_in. If pattern==2**N_INPUTS-1 -> DONE;
//    else pattern+1, probe_out<=pattern+1, cnt reloaded, -> SETTLE.
//  - DONE (1 cycle): done=1, busy=1, pass<=(tt_captured==EXPECT_TT); -> IDLE.
//  - Latency: start sampled at edge k -> done high in cycle k+2**N_INPUTS*(SETTLE_CYCLES+1)+1
//    (N=2,S=2: 13 cycles).
//  - start while busy: ignored, no restart. start in the DONE cycle: ignored.
//  - probe_out changes only on SAMPLE->SETTLE/SAMPLE transitions; never glitches mid-window.
//  - Pattern counter width N_INPUTS+1; no wrap past last pattern. After DONE probe_out
//    holds last pattern until next start.
//  - rst mid-sweep: immediate return to reset values next edge; partial table discarded.
//  - X/Z on probe_in is captured as-is; no filtering.
// CONFIGURATION
//  GATE_PROBER_CLASSIFY_EN defined: func_id decodes tt_captured at DONE (N_INPUTS==2 only,
//   else constant UNKNOWN): 0 UNKNOWN,1 AND(1000),2 OR(1110),3 NAND(0111),4 NOR(0001),
//   5 XOR(0110),6 XNOR(1001); registered, held with pass, reset 0.
//  Undefined: func_id port and decode logic absent; all other behaviour identical.
// STRUCTURE
//  Package gate_probe_pkg: state_t enum {IDLE,SETTLE,SAMPLE,DONE}; func_id_t enum and
//   the six 4-bit truth-table constants; MAX_INPUTS=4.
//  Sub-module settle_timer: loadable down-counter (load, value, expired); one instance.
// TESTING
//  1. NOR model, N=2,S=2, start 1 cycle -> probe_out 0,1,2,3; done at +13; tt=0001; pass=1.
//  2. OR model vs EXPECT_TT=0001 -> tt=1110, pass=0; with CLASSIFY_EN func_id=2.
//  3. S=0 -> each pattern 1 cycle; done at +5; tt correct.
//  4. start held high 20 cycles -> exactly one sweep until IDLE; then second sweep starts.
//  5. rst asserted at cycle 6 of a sweep -> all outputs reset next edge; new start runs clean.
//  6. N=3, 3-input NOR, EXPECT_TT=8'h01 -> 8 patterns, done at +25, pass=1.

Source files
------------

// File: rtl/gate_prober_pkg.sv
// gate_prober package: FSM states, function ids and the 2-input truth-table
// constants used by the optional classifier (GATE_PROBER_CLASSIFY_EN).
package gate_probe_pkg;

    localparam int MAX_INPUTS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        FID_UNKNOWN = 3'd0,
        FID_AND     = 3'd1,
        FID_OR      = 3'd2,
        FID_NAND    = 3'd3,
        FID_NOR     = 3'd4,
        FID_XOR     = 3'd5,
        FID_XNOR    = 3'd6
    } func_id_t;

    // bit i of each table is the gate output for input pattern i
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    function automatic func_id_t classify_tt(input logic [3:0] tt);
        func_id_t fid;
        case (tt)
            TT_AND:  fid = FID_AND;
            TT_OR:   fid = FID_OR;
            TT_NAND: fid = FID_NAND;
            TT_NOR:  fid = FID_NOR;
            TT_XOR:  fid = FID_XOR;
            TT_XNOR: fid = FID_XNOR;
            default: fid = FID_UNKNOWN;
        endcase
        return fid;
    endfunction

endpackage

// File: rtl/gate_prober_if.sv
// gate_prober bus: sweep control/status plus the probe lines to the gate.
// func_id is present only when GATE_PROBER_CLASSIFY_EN is defined.
interface gate_prober_if #(
    parameter int N_INPUTS = 2
);
    import gate_probe_pkg::*;

    logic                      start;
    logic [N_INPUTS-1:0]       probe_out;
    logic                      probe_in;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [(2**N_INPUTS)-1:0]  tt_captured;
`ifdef GATE_PROBER_CLASSIFY_EN
    func_id_t                  func_id;

    modport master (output start, probe_in,
                    input  probe_out, busy, done, pass, tt_captured, func_id);
    modport slave  (input  start, probe_in,
                    output probe_out, busy, done, pass, tt_captured, func_id);
`else
    modport master (output start, probe_in,
                    input  probe_out, busy, done, pass, tt_captured);
    modport slave  (input  start, probe_in,
                    output probe_out, busy, done, pass, tt_captured);
`endif
endinterface

// File: rtl/gate_prober_settle_timer.sv
// settle_timer: loadable 8-bit down-counter; expired marks the last cycle of
// a settle window (count at 1) or an empty window (count at 0).
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] value,
    output logic       expired
);
    logic [7:0] cnt_q, cnt_d;

    // next count: load wins, otherwise count down while enabled, stop at 0
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (en && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q <= 8'd1);
endmodule

// File: rtl/gate_prober.sv
// gate_prober: sweeps every input pattern onto a gate under test, samples its
// output after a settle window and checks the captured truth table.
// Optional: GATE_PROBER_CLASSIFY_EN adds the func_id decode of the table.
//
//  state  | meaning
//  IDLE   | waiting for start; outputs hold last sweep's result
//  SETTLE | probe_out held while the gate output settles
//  SAMPLE | probe_in captured into tt_captured[pattern]
//  DONE   | one-cycle done pulse, pass/func_id valid from here
module gate_prober
    import gate_probe_pkg::*;
#(
    parameter int                      N_INPUTS      = 2,
    parameter int                      SETTLE_CYCLES = 2,
    parameter logic [(2**N_INPUTS)-1:0] EXPECT_TT    = 4'b0001
) (
    input  logic           clk,
    input  logic           rst,
    gate_prober_if.slave   bus
);
    localparam int                NPAT     = 2**N_INPUTS;
    localparam logic [N_INPUTS:0] LAST_PAT = (N_INPUTS+1)'(NPAT - 1);
    localparam logic [7:0]        SETTLE_V = 8'(SETTLE_CYCLES);
    localparam state_t            ST_AFTER_LOAD = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t                state_q, state_d;
    logic [N_INPUTS:0]     pattern_q, pattern_d;
    logic [N_INPUTS-1:0]   probe_out_q, probe_out_d;
    logic [NPAT-1:0]       tt_q, tt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    func_id_t              fid_q, fid_d;
    logic                  tmr_load, tmr_expired;

    settle_timer u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (state_q == SETTLE),
        .value   (SETTLE_V),
        .expired (tmr_expired)
    );

    // sweep sequencing and next values of every registered output
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        probe_out_d = probe_out_q;
        tt_d        = tt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fid_d       = fid_q;
        tmr_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pattern_d   = '0;
                    probe_out_d = '0;
                    tt_d        = '0;
                    pass_d      = 1'b0;
                    fid_d       = FID_UNKNOWN;
                    busy_d      = 1'b1;
                    tmr_load    = 1'b1;
                    state_d     = ST_AFTER_LOAD;
                end
            end
            SETTLE: begin
                if (tmr_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                tt_d[pattern_q[N_INPUTS-1:0]] = bus.probe_in;
                if (pattern_q == LAST_PAT) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (tt_d == EXPECT_TT);
                    fid_d   = (N_INPUTS == 2) ? classify_tt(4'(tt_d)) : FID_UNKNOWN;
                end else begin
                    pattern_d   = pattern_q + 1'b1;
                    probe_out_d = pattern_d[N_INPUTS-1:0];
                    tmr_load    = 1'b1;
                    state_d     = ST_AFTER_LOAD;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            probe_out_q <= '0;
            tt_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fid_q       <= FID_UNKNOWN;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            probe_out_q <= probe_out_d;
            tt_q        <= tt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fid_q       <= fid_d;
        end
    end

    assign bus.probe_out   = probe_out_q;
    assign bus.tt_captured = tt_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
`ifdef GATE_PROBER_CLASSIFY_EN
    assign bus.func_id     = fid_q;
`else
    logic unused_fid;
    assign unused_fid = ^fid_q;
`endif
endmodule
